pc_fetch_seq: RTL and testbench

- Program-counter and instruction-fetch sequencer. It holds the architectural PC and issues fetch requests to instruction memory over a req/gnt/rvalid handshake.
- It presents each fetched instruction to decode with a valid/ready handshake.
- It consumes the incremented PC (PC+INC) internally and accepts branch/jump redirects from execute.
- Sits between the PC adder/branch logic and the imem port at the front of the core.

---
 rtl/pc_fetch_seq.sv | 128 ++++++++++++
 tb/tb_pc_fetch_seq.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_seq.sv
// PC/fetch sequencer: issues imem req/gnt/rvalid fetches at pc and hands words to decode.
// Latency: 1 idle cycle after reset; then REQ->WAIT->HOLD (3 cycles/instr, 2 with FETCH_BYPASS_EN).
// Backpressure: HOLD keeps inst_* stable until inst_ready_i; redirects squash/drop in-flight work.
module pc_fetch_seq #(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          INC      = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req_o,
    output logic [N-1:0] imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [N-1:0] imem_rdata_i,
    input  logic         redirect_valid_i,
    input  logic [N-1:0] redirect_pc_i,
    output logic         inst_valid_o,
    input  logic         inst_ready_i,
    output logic [N-1:0] inst_pc_o,
    output logic [N-1:0] inst_data_o,
    output logic         misalign_err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic         drop_q, drop_d;
    logic [N-1:0] inst_pc_q, inst_pc_d;
    logic [N-1:0] inst_data_q, inst_data_d;
    logic         misalign_q, misalign_d;
    logic [N-1:0] redirect_tgt;
    logic         bypass_go;

    assign redirect_tgt = {redirect_pc_i[N-1:2], 2'b00};

`ifdef FETCH_BYPASS_EN
    // Re-issue straight from HOLD on acceptance; pc already points at the next word.
    assign bypass_go = (state_q == S_HOLD) && inst_ready_i && !redirect_valid_i;
`else
    assign bypass_go = 1'b0;
`endif

    assign imem_req_o     = (state_q == S_REQ) || bypass_go;
    assign imem_addr_o    = pc_q;
    assign inst_valid_o   = (state_q == S_HOLD);
    assign inst_pc_o      = inst_pc_q;
    assign inst_data_o    = inst_data_q;
    assign misalign_err_o = misalign_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        inst_pc_d   = inst_pc_q;
        inst_data_d = inst_data_q;
        misalign_d  = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

        if (redirect_valid_i) begin
            pc_d = redirect_tgt;
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    // A grant in the redirect cycle still owes one response; drop it.
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (imem_gnt_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            inst_data_d = imem_rdata_i;
                            inst_pc_d   = pc_q;
                            pc_d        = pc_q + N'(INC);
                            state_d     = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (inst_ready_i) state_d = (bypass_go && imem_gnt_i) ? S_WAIT : S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            inst_pc_q   <= '0;
            inst_data_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            inst_pc_q   <= inst_pc_d;
            inst_data_q <= inst_data_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed-vector bench for pc_fetch_seq (default build): per-cycle stimulus and expected outputs.
module tb_pc_fetch_seq;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        dv;
        logic [31:0] dpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
        logic [31:0] idata;
        logic        mis;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT0: RESET_PC = 0
    logic        rst0_n, gnt0, rv0, dv0, rdy0;
    logic [31:0] rd0, dpc0;
    logic        req0, iv0, mis0;
    logic [31:0] addr0, ipc0, idata0;
    // DUT1: RESET_PC = FFFF_FFFC
    logic        rst1_n, gnt1, rv1, dv1, rdy1;
    logic [31:0] rd1, dpc1;
    logic        req1, iv1, mis1;
    logic [31:0] addr1, ipc1, idata1;

    pc_fetch_seq #(.N(32), .RESET_PC(32'h0000_0000), .INC(4)) u_dut0 (
        .clk(clk), .rst_n(rst0_n),
        .imem_req_o(req0), .imem_addr_o(addr0), .imem_gnt_i(gnt0),
        .imem_rvalid_i(rv0), .imem_rdata_i(rd0),
        .redirect_valid_i(dv0), .redirect_pc_i(dpc0),
        .inst_valid_o(iv0), .inst_ready_i(rdy0), .inst_pc_o(ipc0),
        .inst_data_o(idata0), .misalign_err_o(mis0)
    );

    pc_fetch_seq #(.N(32), .RESET_PC(32'hFFFF_FFFC), .INC(4)) u_dut1 (
        .clk(clk), .rst_n(rst1_n),
        .imem_req_o(req1), .imem_addr_o(addr1), .imem_gnt_i(gnt1),
        .imem_rvalid_i(rv1), .imem_rdata_i(rd1),
        .redirect_valid_i(dv1), .redirect_pc_i(dpc1),
        .inst_valid_o(iv1), .inst_ready_i(rdy1), .inst_pc_o(ipc1),
        .inst_data_o(idata1), .misalign_err_o(mis1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    vec_t tbl[$];
    vec_t wtbl[$];

    function automatic vec_t mk(input logic g, input logic r, input logic [31:0] d,
                                input logic v, input logic [31:0] p, input logic y,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ed, input logic em);
        vec_t t;
        t.gnt = g; t.rv = r; t.rd = d; t.dv = v; t.dpc = p; t.rdy = y;
        t.req = eq; t.addr = ea; t.iv = ev; t.ipc = ep; t.idata = ed; t.mis = em;
        return t;
    endfunction

    task automatic check(input string name, input bit sel, input logic eq, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ep, input logic [31:0] ed, input logic em);
        logic        aq, av, am;
        logic [31:0] aa, ap, ad;
        aq = sel ? req1 : req0;   aa = sel ? addr1 : addr0;
        av = sel ? iv1 : iv0;     ap = sel ? ipc1 : ipc0;
        ad = sel ? idata1 : idata0; am = sel ? mis1 : mis0;
        n_tests++;
        if (aq !== eq || aa !== ea || av !== ev || ap !== ep || ad !== ed || am !== em) begin
            n_fail++;
            $display("FAIL %s: got req=%b addr=%h iv=%b ipc=%h data=%h mis=%b, want req=%b addr=%h iv=%b ipc=%h data=%h mis=%b",
                     name, aq, aa, av, ap, ad, am, eq, ea, ev, ep, ed, em);
        end
    endtask

    task automatic step(input vec_t t, input bit sel, input string name);
        if (sel) begin
            gnt1 = t.gnt; rv1 = t.rv; rd1 = t.rd; dv1 = t.dv; dpc1 = t.dpc; rdy1 = t.rdy;
        end else begin
            gnt0 = t.gnt; rv0 = t.rv; rd0 = t.rd; dv0 = t.dv; dpc0 = t.dpc; rdy0 = t.rdy;
        end
        #1;
        check(name, sel, t.req, t.addr, t.iv, t.ipc, t.idata, t.mis);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I0 = 32'h1111_0000, I1 = 32'h2222_0001, I2 = 32'h3333_0002;
    localparam logic [31:0] I3 = 32'h4444_0003, I4 = 32'h5555_0004, I5 = 32'h6666_0005;
    localparam logic [31:0] W0 = 32'hA5A5_0000, W1 = 32'hA5A5_0001;

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        gnt0 = 0; rv0 = 0; rd0 = 0; dv0 = 0; dpc0 = 0; rdy0 = 0;
        gnt1 = 0; rv1 = 0; rd1 = 0; dv1 = 0; dpc1 = 0; rdy1 = 0;

        // gnt, rv, rdata, redir_v, redir_pc, rdy | req, addr, iv, ipc, idata, mis
        tbl.push_back(mk(1,0,0,0,0,1, 0,32'h0,0,32'h0,0,0));          // IDLE
        tbl.push_back(mk(1,0,0,0,0,1, 1,32'h0,0,32'h0,0,0));          // REQ 0
        tbl.push_back(mk(1,1,I0,0,0,1, 0,32'h0,0,32'h0,0,0));         // WAIT
        tbl.push_back(mk(1,0,0,0,0,1, 0,32'h4,1,32'h0,I0,0));         // HOLD 0
        tbl.push_back(mk(1,0,0,0,0,1, 1,32'h4,0,32'h0,I0,0));
        tbl.push_back(mk(1,1,I1,0,0,1, 0,32'h4,0,32'h0,I0,0));
        for (int k = 0; k < 5; k++)                                     // backpressure
            tbl.push_back(mk(0,0,0,0,0,0, 0,32'h8,1,32'h4,I1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,32'h8,1,32'h4,I1,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,32'h8,0,32'h4,I1,0));
        tbl.push_back(mk(1,1,I2,0,0,1, 0,32'h8,0,32'h4,I1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,32'hC,1,32'h8,I2,0));         // HOLD 8
        tbl.push_back(mk(1,0,0,0,0,0, 1,32'hC,0,32'h8,I2,0));
        tbl.push_back(mk(0,0,0,1,32'h100,0, 0,32'hC,0,32'h8,I2,0));   // redirect in WAIT
        tbl.push_back(mk(0,0,0,0,0,0, 0,32'h100,0,32'h8,I2,0));
        tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,0,0, 0,32'h100,0,32'h8,I2,0)); // dropped
        tbl.push_back(mk(1,0,0,0,0,0, 1,32'h100,0,32'h8,I2,0));
        tbl.push_back(mk(0,1,I3,0,0,0, 0,32'h100,0,32'h8,I2,0));
        tbl.push_back(mk(0,0,0,1,32'h200,1, 0,32'h104,1,32'h100,I3,0)); // redirect in HOLD
        tbl.push_back(mk(0,0,0,0,0,0, 1,32'h200,0,32'h100,I3,0));
        tbl.push_back(mk(0,0,0,0,0,0, 1,32'h200,0,32'h100,I3,0));     // stall, addr stable
        tbl.push_back(mk(0,0,0,1,32'h106,0, 1,32'h200,0,32'h100,I3,0)); // misaligned
        tbl.push_back(mk(1,0,0,0,0,0, 1,32'h104,0,32'h100,I3,1));
        tbl.push_back(mk(0,1,I4,0,0,0, 0,32'h104,0,32'h100,I3,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,32'h108,1,32'h104,I4,0));
        tbl.push_back(mk(1,0,0,1,32'h300,0, 1,32'h108,0,32'h104,I4,0)); // redirect + gnt
        tbl.push_back(mk(0,1,32'hBAD0_BAD0,0,0,0, 0,32'h300,0,32'h104,I4,0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,32'h300,0,32'h104,I4,0));
        tbl.push_back(mk(0,1,I5,0,0,0, 0,32'h300,0,32'h104,I4,0));
        tbl.push_back(mk(0,0,0,0,0,1, 0,32'h304,1,32'h300,I5,0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,32'h304,0,32'h300,I5,0));     // -> WAIT

        wtbl.push_back(mk(1,0,0,0,0,1, 0,32'hFFFF_FFFC,0,32'h0,0,0));
        wtbl.push_back(mk(1,0,0,0,0,1, 1,32'hFFFF_FFFC,0,32'h0,0,0));
        wtbl.push_back(mk(1,1,W0,0,0,1, 0,32'hFFFF_FFFC,0,32'h0,0,0));
        wtbl.push_back(mk(1,0,0,0,0,1, 0,32'h0,1,32'hFFFF_FFFC,W0,0));
        wtbl.push_back(mk(1,0,0,0,0,1, 1,32'h0,0,32'hFFFF_FFFC,W0,0));
        wtbl.push_back(mk(1,1,W1,0,0,1, 0,32'h0,0,32'hFFFF_FFFC,W0,0));
        wtbl.push_back(mk(1,0,0,0,0,1, 0,32'h4,1,32'h0,W1,0));

        repeat (2) @(posedge clk);
        #1;
        check("reset0", 1'b0, 0, 32'h0, 0, 32'h0, 32'h0, 0);
        check("reset1", 1'b1, 0, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
        rst0_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], 1'b0, $sformatf("main%0d", i));

        // Async reset while DUT0 waits on a response: outputs clear with no clock edge.
        rst0_n = 1'b0;
        #1;
        check("async_rst", 1'b0, 0, 32'h0, 0, 32'h0, 32'h0, 0);

        rst1_n = 1'b1;
        for (int i = 0; i < wtbl.size(); i++)
            step(wtbl[i], 1'b1, $sformatf("wrap%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
